// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_issue_arbiter                                               |
// | Purpose  : two-requester ALU issue arbiter with issue and writeback stages |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu_issue_arbiter #(
   parameter int PRIO_MODE = 0
) (
   input  logic        clk,
   input  logic        reset_n,

   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic [6:0]  r0_opcode,
   input  logic [6:0]  r0_func7,
   input  logic [2:0]  r0_func3,
   input  logic [63:0] r0_rs1,
   input  logic [63:0] r0_rs2,
   input  logic [63:0] r0_pc,
   input  logic [19:0] r0_imm,
   input  logic [4:0]  r0_rd_indx,

   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic [6:0]  r1_opcode,
   input  logic [6:0]  r1_func7,
   input  logic [2:0]  r1_func3,
   input  logic [63:0] r1_rs1,
   input  logic [63:0] r1_rs2,
   input  logic [63:0] r1_pc,
   input  logic [19:0] r1_imm,
   input  logic [4:0]  r1_rd_indx,

   output logic [6:0]  alu_opcode,
   output logic [6:0]  alu_func7,
   output logic [2:0]  alu_func3,
   output logic [63:0] alu_rs1,
   output logic [63:0] alu_rs2,
   output logic [19:0] alu_imm,
   output logic [63:0] alu_pc,
   output logic [4:0]  alu_rd_indx,
   output logic        alu_valid,

   input  logic [63:0] alu_rd,
   input  logic        alu_o_valid,
   input  logic [4:0]  alu_o_rd_indx,

   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd_indx,
   output logic [63:0] wb_data,
   output logic        wb_src,
   output logic        busy
);

   logic        iss_valid;
   logic        iss_src;
   logic        grant0;
   logic        grant1;
   logic        res_free;
   logic        iss_free;
   logic        xfer0;
   logic        xfer1;
   logic        xfer;

   assign res_free = !wb_valid || wb_ready;
   assign iss_free = !iss_valid || res_free;
   assign r0_ready = grant0 && iss_free;
   assign r1_ready = grant1 && iss_free;
   assign xfer0    = r0_valid && r0_ready;
   assign xfer1    = r1_valid && r1_ready;
   assign xfer     = xfer0 || xfer1;

   generate
      if (PRIO_MODE == 1) begin : g_fixed
         always_comb begin
            grant0 = r0_valid;
            grant1 = r1_valid && !r0_valid;
         end
      end else begin : g_rr
         // last_grant: 1 means requester 1 won the most recent transfer
         logic last_grant;

         always_comb begin
            grant0 = r0_valid && (!r1_valid || last_grant);
            grant1 = r1_valid && (!r0_valid || !last_grant);
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               last_grant <= 1'b1;
            end else if (xfer) begin
               last_grant <= xfer1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         iss_valid   <= 1'b0;
         iss_src     <= 1'b0;
         alu_opcode  <= '0;
         alu_func7   <= '0;
         alu_func3   <= '0;
         alu_rs1     <= '0;
         alu_rs2     <= '0;
         alu_imm     <= '0;
         alu_pc      <= '0;
         alu_rd_indx <= '0;
      end else if (xfer) begin
         iss_valid   <= 1'b1;
         iss_src     <= xfer1;
         alu_opcode  <= xfer1 ? r1_opcode  : r0_opcode;
         alu_func7   <= xfer1 ? r1_func7   : r0_func7;
         alu_func3   <= xfer1 ? r1_func3   : r0_func3;
         alu_rs1     <= xfer1 ? r1_rs1     : r0_rs1;
         alu_rs2     <= xfer1 ? r1_rs2     : r0_rs2;
         alu_imm     <= xfer1 ? r1_imm     : r0_imm;
         alu_pc      <= xfer1 ? r1_pc      : r0_pc;
         alu_rd_indx <= xfer1 ? r1_rd_indx : r0_rd_indx;
      end else if (res_free) begin
         iss_valid   <= 1'b0;
      end
   end

   assign alu_valid = iss_valid;

   // Writes to x0 retire here without ever raising wb_valid
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_valid   <= 1'b0;
         wb_rd_indx <= '0;
         wb_data    <= '0;
         wb_src     <= 1'b0;
      end else if (iss_valid && res_free) begin
         wb_valid   <= alu_o_valid && (alu_o_rd_indx != 5'd0);
         wb_rd_indx <= alu_o_rd_indx;
         wb_data    <= alu_rd;
         wb_src     <= iss_src;
      end else if (wb_ready) begin
         wb_valid   <= 1'b0;
      end
   end

   assign busy = iss_valid || wb_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_issue_arbiter                                            |
// | Purpose  : scoreboard bench for alu_issue_arbiter (round-robin and fixed)  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu_issue_arbiter;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [6:0]  func7;
      logic [2:0]  func3;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [63:0] pc;
      logic [19:0] imm;
      logic [4:0]  rd;
   } op_t;

   typedef struct packed {
      logic        src;
      logic [4:0]  rd;
      logic [63:0] data;
   } res_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Environment ALU; non-commutative cases catch swapped or corrupted fields
   function automatic logic [63:0] alu_fn(input op_t o);
      logic [63:0] r;
      case (o.func3)
         3'd0:    r = (o.func7 == 7'h20) ? o.rs1 - o.rs2 : o.rs1 + o.rs2;
         3'd1:    r = o.rs1 << o.rs2[5:0];
         3'd4:    r = o.rs1 ^ o.rs2;
         3'd7:    r = o.rs1 & o.rs2;
         default: r = o.rs1 + {{44{o.imm[19]}}, o.imm} + o.pc
                      + {57'd0, o.opcode} + {57'd0, o.func7} + {59'd0, o.rd};
      endcase
      return r;
   endfunction

   function automatic op_t rand_op(input bit nz);
      op_t o;
      o.opcode = 7'($urandom);
      o.func7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
      o.func3  = 3'($urandom);
      o.rs1    = {$urandom, $urandom};
      o.rs2    = {$urandom, $urandom};
      o.pc     = {$urandom, $urandom};
      o.imm    = 20'($urandom);
      o.rd     = nz ? 5'($urandom_range(1, 31)) : 5'($urandom);
      return o;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- round-robin DUT ----------------
   logic        m_v0 = 1'b0, m_v1 = 1'b0, m_rdy0, m_rdy1;
   op_t         m_op0 = '0, m_op1 = '0;
   logic [6:0]  m_alu_opcode, m_alu_func7;
   logic [2:0]  m_alu_func3;
   logic [63:0] m_alu_rs1, m_alu_rs2, m_alu_pc, m_alu_rd;
   logic [19:0] m_alu_imm;
   logic [4:0]  m_alu_rd_indx, m_wb_rd_indx;
   logic        m_alu_valid, m_wb_valid, m_wb_src, m_busy;
   logic        m_wb_ready = 1'b1;
   logic [63:0] m_wb_data;
   op_t         m_alu_view;

   always_comb begin
      m_alu_view = {m_alu_opcode, m_alu_func7, m_alu_func3, m_alu_rs1, m_alu_rs2,
                    m_alu_pc, m_alu_imm, m_alu_rd_indx};
      m_alu_rd   = alu_fn(m_alu_view);
   end

   alu_issue_arbiter #(.PRIO_MODE(0)) u_rr (
      .clk(clk), .reset_n(reset_n),
      .r0_valid(m_v0), .r0_ready(m_rdy0), .r0_opcode(m_op0.opcode), .r0_func7(m_op0.func7),
      .r0_func3(m_op0.func3), .r0_rs1(m_op0.rs1), .r0_rs2(m_op0.rs2), .r0_pc(m_op0.pc),
      .r0_imm(m_op0.imm), .r0_rd_indx(m_op0.rd),
      .r1_valid(m_v1), .r1_ready(m_rdy1), .r1_opcode(m_op1.opcode), .r1_func7(m_op1.func7),
      .r1_func3(m_op1.func3), .r1_rs1(m_op1.rs1), .r1_rs2(m_op1.rs2), .r1_pc(m_op1.pc),
      .r1_imm(m_op1.imm), .r1_rd_indx(m_op1.rd),
      .alu_opcode(m_alu_opcode), .alu_func7(m_alu_func7), .alu_func3(m_alu_func3),
      .alu_rs1(m_alu_rs1), .alu_rs2(m_alu_rs2), .alu_imm(m_alu_imm), .alu_pc(m_alu_pc),
      .alu_rd_indx(m_alu_rd_indx), .alu_valid(m_alu_valid),
      .alu_rd(m_alu_rd), .alu_o_valid(m_alu_valid), .alu_o_rd_indx(m_alu_rd_indx),
      .wb_valid(m_wb_valid), .wb_ready(m_wb_ready), .wb_rd_indx(m_wb_rd_indx),
      .wb_data(m_wb_data), .wb_src(m_wb_src), .busy(m_busy)
   );

   // ---------------- fixed-priority DUT ----------------
   logic        f_v0 = 1'b0, f_v1 = 1'b0, f_rdy0, f_rdy1;
   op_t         f_op0 = '0, f_op1 = '0;
   logic [6:0]  f_alu_opcode, f_alu_func7;
   logic [2:0]  f_alu_func3;
   logic [63:0] f_alu_rs1, f_alu_rs2, f_alu_pc, f_alu_rd;
   logic [19:0] f_alu_imm;
   logic [4:0]  f_alu_rd_indx, f_wb_rd_indx;
   logic        f_alu_valid, f_wb_valid, f_wb_src, f_busy;
   logic        f_wb_ready = 1'b1;
   logic [63:0] f_wb_data;
   op_t         f_alu_view;

   always_comb begin
      f_alu_view = {f_alu_opcode, f_alu_func7, f_alu_func3, f_alu_rs1, f_alu_rs2,
                    f_alu_pc, f_alu_imm, f_alu_rd_indx};
      f_alu_rd   = alu_fn(f_alu_view);
   end

   alu_issue_arbiter #(.PRIO_MODE(1)) u_fix (
      .clk(clk), .reset_n(reset_n),
      .r0_valid(f_v0), .r0_ready(f_rdy0), .r0_opcode(f_op0.opcode), .r0_func7(f_op0.func7),
      .r0_func3(f_op0.func3), .r0_rs1(f_op0.rs1), .r0_rs2(f_op0.rs2), .r0_pc(f_op0.pc),
      .r0_imm(f_op0.imm), .r0_rd_indx(f_op0.rd),
      .r1_valid(f_v1), .r1_ready(f_rdy1), .r1_opcode(f_op1.opcode), .r1_func7(f_op1.func7),
      .r1_func3(f_op1.func3), .r1_rs1(f_op1.rs1), .r1_rs2(f_op1.rs2), .r1_pc(f_op1.pc),
      .r1_imm(f_op1.imm), .r1_rd_indx(f_op1.rd),
      .alu_opcode(f_alu_opcode), .alu_func7(f_alu_func7), .alu_func3(f_alu_func3),
      .alu_rs1(f_alu_rs1), .alu_rs2(f_alu_rs2), .alu_imm(f_alu_imm), .alu_pc(f_alu_pc),
      .alu_rd_indx(f_alu_rd_indx), .alu_valid(f_alu_valid),
      .alu_rd(f_alu_rd), .alu_o_valid(f_alu_valid), .alu_o_rd_indx(f_alu_rd_indx),
      .wb_valid(f_wb_valid), .wb_ready(f_wb_ready), .wb_rd_indx(f_wb_rd_indx),
      .wb_data(f_wb_data), .wb_src(f_wb_src), .busy(f_busy)
   );

   // ---------------- scoreboard monitor for the round-robin DUT ----------------
   res_t sbq[$];
   int   last_win = 1;
   int   wb_count = 0;
   logic held = 1'b0;
   res_t held_v = '0;

   initial begin : monitor
      logic xf0, xf1;
      op_t  o;
      res_t r, got;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            held = 1'b0;
         end else begin
            check("ready_onehot", {127'd0, m_rdy0 & m_rdy1}, 128'd0);
            got = {m_wb_src, m_wb_rd_indx, m_wb_data};
            if (held) begin
               check("wb_hold_valid", {127'd0, m_wb_valid}, 128'd1);
               check("wb_hold_data", {58'd0, got}, {58'd0, held_v});
            end
            xf0 = m_v0 & m_rdy0;
            xf1 = m_v1 & m_rdy1;
            if (xf0 || xf1) begin
               if (m_v0 && m_v1)
                  check("rr_grant", {127'd0, xf1}, {127'd0, (last_win == 0)});
               last_win = xf1 ? 1 : 0;
               o = xf1 ? m_op1 : m_op0;
               if (o.rd != 5'd0) begin
                  r.src  = xf1;
                  r.rd   = o.rd;
                  r.data = alu_fn(o);
                  sbq.push_back(r);
               end
            end
            if (m_wb_valid && m_wb_ready) begin
               wb_count++;
               if (sbq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL wb_unexpected: got %0h expected none", got);
               end else begin
                  r = sbq.pop_front();
                  check("wb_result", {58'd0, got}, {58'd0, r});
               end
            end
            held   = m_wb_valid & !m_wb_ready;
            held_v = got;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset_n    = 1'b0;
      m_v0       = 1'b0;
      m_v1       = 1'b0;
      f_v0       = 1'b0;
      f_v1       = 1'b0;
      m_wb_ready = 1'b1;
      sbq.delete();
      last_win   = 1;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      op_t  o;
      int   base;
      int   sent;
      logic acc0, acc1;

      // reset state and single ADD latency
      do_reset();
      @(negedge clk);
      check("rst_wb_valid", {127'd0, m_wb_valid}, 128'd0);
      check("rst_alu_valid", {127'd0, m_alu_valid}, 128'd0);
      check("rst_busy", {127'd0, m_busy}, 128'd0);
      check("rst_wb_fields", {58'd0, m_wb_src, m_wb_rd_indx, m_wb_data}, 128'd0);
      check("rst_ready", {126'd0, m_rdy0, m_rdy1}, 128'd0);
      @(posedge clk); #1;
      o = '0;
      o.opcode = 7'b0110011;
      o.rs1 = 64'd5;
      o.rs2 = 64'd7;
      o.rd  = 5'd3;
      m_op0 = o;
      m_v0  = 1'b1;
      @(negedge clk);
      check("add_ready", {127'd0, m_rdy0}, 128'd1);
      @(posedge clk); #1 m_v0 = 1'b0;
      @(negedge clk);
      check("add_lat_wb_early", {127'd0, m_wb_valid}, 128'd0);
      check("add_alu_valid", {127'd0, m_alu_valid}, 128'd1);
      @(negedge clk);
      check("add_wb_valid", {127'd0, m_wb_valid}, 128'd1);
      check("add_wb_data", {64'd0, m_wb_data}, 128'd12);
      check("add_wb_rd", {123'd0, m_wb_rd_indx}, 128'd3);
      check("add_wb_src", {127'd0, m_wb_src}, 128'd0);

      // round-robin alternation with both requesters saturated
      do_reset();
      base = wb_count;
      @(posedge clk); #1;
      m_op0 = rand_op(1);
      m_op1 = rand_op(1);
      m_v0 = 1'b1;
      m_v1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("rr_r0_ready", {127'd0, m_rdy0}, {127'd0, (i % 2 == 0)});
         check("rr_r1_ready", {127'd0, m_rdy1}, {127'd0, (i % 2 == 1)});
         @(posedge clk); #1;
         if (i % 2 == 0) m_op0 = rand_op(1);
         else            m_op1 = rand_op(1);
      end
      m_v0 = 1'b0;
      m_v1 = 1'b0;
      repeat (4) @(posedge clk);
      check("rr_wb_count", 128'(wb_count - base), 128'd6);

      // four-op stream with writeback stalled in cycles 3-5
      do_reset();
      base = wb_count;
      sent = 0;
      acc0 = 1'b0;
      m_op0 = rand_op(1);
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (acc0) begin
            sent++;
            m_op0 = rand_op(1);
         end
         m_v0 = (sent < 4);
         m_wb_ready = !(c >= 3 && c <= 5);
         @(negedge clk);
         if (m_v0)
            check("stall_ready", {127'd0, m_rdy0}, {127'd0, !(c >= 3 && c <= 5)});
         acc0 = m_v0 & m_rdy0;
      end
      check("stall_wb_count", 128'(wb_count - base), 128'd4);
      check("stall_sb_empty", 128'(sbq.size()), 128'd0);

      // x0 destination is retired silently
      base = wb_count;
      @(posedge clk); #1;
      o = rand_op(1);
      o.rd = 5'd0;
      m_op1 = o;
      m_v1 = 1'b1;
      @(negedge clk);
      check("rd0_ready_a", {127'd0, m_rdy1}, 128'd1);
      @(posedge clk); #1;
      o = rand_op(1);
      o.rd = 5'd5;
      m_op1 = o;
      @(negedge clk);
      check("rd0_ready_b", {127'd0, m_rdy1}, 128'd1);
      @(posedge clk); #1 m_v1 = 1'b0;
      repeat (4) @(posedge clk);
      check("rd0_wb_count", 128'(wb_count - base), 128'd1);

      // reset with both stages occupied
      do_reset();
      m_wb_ready = 1'b0;
      @(posedge clk); #1;
      m_op1 = rand_op(1);
      m_v1 = 1'b1;
      @(posedge clk); #1 m_op1 = rand_op(1);
      @(posedge clk); #1 m_v1 = 1'b0;
      @(negedge clk);
      check("pre_rst_wb_valid", {127'd0, m_wb_valid}, 128'd1);
      check("pre_rst_alu_valid", {127'd0, m_alu_valid}, 128'd1);
      #1 reset_n = 1'b0;
      #1;
      check("async_rst_wb_valid", {127'd0, m_wb_valid}, 128'd0);
      check("async_rst_alu_valid", {127'd0, m_alu_valid}, 128'd0);
      check("async_rst_busy", {127'd0, m_busy}, 128'd0);
      check("async_rst_wb_fields", {58'd0, m_wb_src, m_wb_rd_indx, m_wb_data}, 128'd0);
      sbq.delete();
      last_win = 1;
      m_wb_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      base = wb_count;
      repeat (6) @(posedge clk);
      check("post_rst_no_wb", 128'(wb_count - base), 128'd0);

      // randomized traffic with random backpressure
      acc0 = 1'b0;
      acc1 = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         if (acc0 || !m_v0) begin
            m_v0  = ($urandom_range(0, 99) < 60);
            m_op0 = rand_op(0);
         end
         if (acc1 || !m_v1) begin
            m_v1  = ($urandom_range(0, 99) < 60);
            m_op1 = rand_op(0);
         end
         m_wb_ready = ($urandom_range(0, 99) < 70);
         @(negedge clk);
         acc0 = m_v0 & m_rdy0;
         acc1 = m_v1 & m_rdy1;
      end
      @(posedge clk); #1;
      m_v0 = 1'b0;
      m_v1 = 1'b0;
      m_wb_ready = 1'b1;
      repeat (6) @(posedge clk);
      check("rand_sb_empty", 128'(sbq.size()), 128'd0);

      // fixed priority: r1 only wins once r0 drops
      @(posedge clk); #1;
      f_op0 = rand_op(1);
      o = rand_op(1);
      o.rd = 5'd7;
      f_op1 = o;
      f_v0 = 1'b1;
      f_v1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("fix_r1_blocked", {127'd0, f_rdy1}, 128'd0);
         check("fix_r0_ready", {127'd0, f_rdy0}, 128'd1);
         @(posedge clk); #1 f_op0 = rand_op(1);
      end
      f_v0 = 1'b0;
      @(negedge clk);
      check("fix_r1_take", {127'd0, f_rdy1}, 128'd1);
      @(posedge clk); #1 f_v1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("fix_wb_valid", {127'd0, f_wb_valid}, 128'd1);
      check("fix_wb_src", {127'd0, f_wb_src}, 128'd1);
      check("fix_wb_rd", {123'd0, f_wb_rd_indx}, 128'd7);
      check("fix_wb_data", {64'd0, f_wb_data}, {64'd0, alu_fn(o)});

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
